hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
// - Producer of the ID_EX Flush input and the EX-stage MUX3 forwarding selects.
// - Tracks in-flight destination registers through MEM/WB with internal shadow registers.
// - Detects load-use hazards (stall F/D, bubble E) and taken-branch/jump redirects (flush).
// - Keeps saturating performance counters for stalls and flushes.
// PARAMETERS
// - CNT_W  16  width of stall_cnt and flush_cnt.
// PORTS
// - CLOCK       in   1      pipeline clock; all state changes on posedge.
// - RESET       in   1      reset, asynchronous, active-high.
// - Rs_D        in   5      rs field of the instruction in decode.
// - Rt_D        in   5      rt field of the instruction in decode.
// - Rs_E        in   5      Rs_out of ID_EX.
// - Rt_E        in   5      Rt_out of ID_EX.
// - WriteReg_E  in   5      EX destination register, rt or rd after the RegDst MUX2_BIT5.
// - RegWrite_E  in   1      RegWrite_out of ID_EX.
// - MemtoReg_E  in   1      MemtoReg_out of ID_EX; 1 means lw.
// - PCSrc_E     in   1      branch resolved taken in EX.
// - Jump_D      in   1      j/jal/jr decoded in D.
// - Stall_F     out  1      hold PC.
// - Stall_D     out  1      hold IF_ID.
// - Flush_D     out  1      clear IF_ID.
// - Flush_E     out  1      drives ID_EX Flush.
// - ForwardA_E  out  2      SrcA MUX3 select: 00 register, 01 MEM ALU result, 10 WB result.
// - ForwardB_E  out  2      SrcB MUX3 select, same encoding.
// - stall_cnt   out  CNT_W  count of load-use stall cycles.
// - flush_cnt   out  CNT_W  count of redirect cycles.
// BEHAVIOUR
// - Shadow state, updated each posedge:
//   - wr_M<=WriteReg_E, rw_M<=RegWrite_E.
//   - wr_W<=wr_M, rw_W<=rw_M.
//   - Never stalled; ID_EX flush already zeroes RegWrite_E.
// - RESET (async) sets wr_M/wr_W=0, rw_M/rw_W=0, and both counters=0.
// - While RESET is high, outputs are forced as follows:
//   - Stall_F=Stall_D=0.
//   - Flush_D=Flush_E=1.
//   - Forward*=00.
//   - The same holds for a reset asserted mid-operation.
// - Forwarding is combinational, with MEM priority over WB. For ForwardA_E:
//   - 01 if rw_M && wr_M!=0 && wr_M==Rs_E.
//   - Else 10 if rw_W && wr_W!=0 && wr_W==Rs_E.
//   - Else 00.
// - ForwardB_E uses the same rules with Rt_E. Register $0 is never forwarded. Code 11 is never driven.
// - lwstall = MemtoReg_E && RegWrite_E && WriteReg_E!=0 && (WriteReg_E==Rs_D || WriteReg_E==Rt_D).
// - redirect = PCSrc_E || Jump_D.
// - Stall_F = Stall_D = lwstall && !PCSrc_E; a taken branch kills the wrong-path D instruction, so no stall.
// - Flush_D = redirect.
// - Flush_E = lwstall || PCSrc_E.
// - Jump_D and lwstall together: stall wins for F/D and Flush_D=1 still; the jump is re-decoded next cycle.
// - Latency: hazard outputs are same-cycle combinational. The bubble reaches EX one cycle later via ID_EX.
// - Load-use costs exactly 1 stall cycle; the following cycle forwards from MEM... WB (10) path for lw data.
// - Counters, registered:
//   - stall_cnt += 1 on cycles with Stall_D=1.
//   - flush_cnt += 1 on cycles with redirect=1.
//   - Both saturate at 2^CNT_W-1 with no wrap.
// STRUCTURE
// - pipeline_pkg: FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, REG_ZERO=5'd0, OP_LW=6'h23.
// - Sub-module sat_counter #(W), instantiated twice: inc, clear on RESET, saturating output.
// - Remainder of the block: shadow registers plus combinational compare logic.
// TESTING
// - Back-to-back add $3 then add $5,$3,$4:
//   - Cycle 2: Rs_E=3, wr_M=3, rw_M=1 -> ForwardA_E=01.
//   - Next cycle: WB only -> 10.
// - Write to $0 followed by a read of $0 -> Forward*=00 in both the MEM and WB slots.
// - lw $2 in E (MemtoReg_E=1, WriteReg_E=2), Rt_D=2:
//   - Stall_F=Stall_D=Flush_E=1 for one cycle.
//   - stall_cnt 0->1.
//   - Then ForwardB_E=10.
// - PCSrc_E=1 with a simultaneous lwstall condition:
//   - Stall_*=0, Flush_D=Flush_E=1.
//   - flush_cnt+1, stall_cnt unchanged.
// - Assert RESET mid-stream with wr_M=7:
//   - Outputs immediately forced (Flush_*=1, Forward*=00).
//   - After release, Rs_E=7 -> 00.
// - CNT_W=2, hold Jump_D=1 for 5 cycles -> flush_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: forwarding-select codes, the hard-wired zero
// register and the lw opcode, plus the MEM-over-WB forwarding priority rule.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,   // operand straight from the register file
      FWD_MEM = 2'b01,   // ALU result sitting in EX/MEM
      FWD_WB  = 2'b10    // result being written back from MEM/WB
   } fwd_sel_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [5:0] OP_LW    = 6'h23;

   // The youngest in-flight writer wins; $0 is hard-wired and never forwarded.
   function automatic fwd_sel_e fwd_select(input logic       rw_m,
                                           input logic [4:0] wr_m,
                                           input logic       rw_w,
                                           input logic [4:0] wr_w,
                                           input logic [4:0] src);
      fwd_sel_e sel;
      sel = FWD_REG;
      if (rw_m && (wr_m != REG_ZERO) && (wr_m == src))
         sel = FWD_MEM;
      else if (rw_w && (wr_w != REG_ZERO) && (wr_w == src))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_forward_unit_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count one per cycle with inc high, holding at the maximum value.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for the 5-stage pipeline: tracks EX
// destinations through MEM/WB, selects EX operand bypasses, raises load-use
// stalls and redirect flushes, and counts stall/flush cycles.
module hazard_forward_unit
   import pipeline_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [4:0]       Rs_D,
   input  logic [4:0]       Rt_D,
   input  logic [4:0]       Rs_E,
   input  logic [4:0]       Rt_E,
   input  logic [4:0]       WriteReg_E,
   input  logic             RegWrite_E,
   input  logic             MemtoReg_E,
   input  logic             PCSrc_E,
   input  logic             Jump_D,
   output logic             Stall_F,
   output logic             Stall_D,
   output logic             Flush_D,
   output logic             Flush_E,
   output logic [1:0]       ForwardA_E,
   output logic [1:0]       ForwardB_E,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [4:0] wr_m, wr_w;
   logic       rw_m, rw_w;
   logic       lwstall;
   logic       redirect;

   // Shadow copies of the destination register as it moves through MEM and WB.
   // A flushed ID_EX already presents RegWrite_E=0, so these never need to stall.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         wr_m <= REG_ZERO;
         rw_m <= 1'b0;
         wr_w <= REG_ZERO;
         rw_w <= 1'b0;
      end else begin
         wr_m <= WriteReg_E;
         rw_m <= RegWrite_E;
         wr_w <= wr_m;
         rw_w <= rw_m;
      end
   end

   // Same-cycle hazard detection, bypass selection and reset output forcing.
   always_comb begin
      // NOTE: every output gets a default first so no path through this block infers a latch.
      Stall_F    = 1'b0;
      Stall_D    = 1'b0;
      Flush_D    = 1'b1;
      Flush_E    = 1'b1;
      ForwardA_E = FWD_REG;
      ForwardB_E = FWD_REG;

      lwstall  = MemtoReg_E && RegWrite_E && (WriteReg_E != REG_ZERO) &&
                 ((WriteReg_E == Rs_D) || (WriteReg_E == Rt_D));
      redirect = PCSrc_E || Jump_D;

      if (!RESET) begin
         // A taken branch kills the wrong-path D instruction, so it must not stall.
         Stall_F    = lwstall && !PCSrc_E;
         Stall_D    = lwstall && !PCSrc_E;
         Flush_D    = redirect;
         Flush_E    = lwstall || PCSrc_E;
         ForwardA_E = fwd_select(rw_m, wr_m, rw_w, wr_w, Rs_E);
         ForwardB_E = fwd_select(rw_m, wr_m, rw_w, wr_w, Rt_E);
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .inc   (Stall_D),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .inc   (redirect),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding priority, $0 handling,
// load-use stall, branch/jump redirects, mid-run reset and counter saturation.
module tb_hazard_forward_unit;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E;
   logic        RegWrite_E, MemtoReg_E, PCSrc_E, Jump_D;

   logic        Stall_F, Stall_D, Flush_D, Flush_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_Stall_F, s_Stall_D, s_Flush_D, s_Flush_E;
   logic [1:0]  s_ForwardA_E, s_ForwardB_E;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_forward_unit #(.CNT_W(16)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
      .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
      .PCSrc_E(PCSrc_E), .Jump_D(Jump_D),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Narrow-counter copy fed the same stimulus, used for the saturation check.
   hazard_forward_unit #(.CNT_W(2)) dut_small (
      .CLOCK(CLOCK), .RESET(RESET),
      .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
      .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
      .PCSrc_E(PCSrc_E), .Jump_D(Jump_D),
      .Stall_F(s_Stall_F), .Stall_D(s_Stall_D), .Flush_D(s_Flush_D), .Flush_E(s_Flush_E),
      .ForwardA_E(s_ForwardA_E), .ForwardB_E(s_ForwardB_E),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance past the next rising edge; inputs change 1 time unit later.
   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic set_e(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                        input logic rw, input logic m2r);
      Rs_E = rs; Rt_E = rt; WriteReg_E = wr; RegWrite_E = rw; MemtoReg_E = m2r;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      RESET = 1'b1;
      Rs_D = 0; Rt_D = 0; PCSrc_E = 0; Jump_D = 0;
      set_e(0, 0, 0, 0, 0);

      // Reset state: outputs forced, counters cleared.
      #3;
      check("rst_stall_f", Stall_F, 0);
      check("rst_flush_d", Flush_D, 1);
      check("rst_flush_e", Flush_E, 1);
      check("rst_fwd_a", ForwardA_E, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
      #9 RESET = 1'b0;

      // add $3 in E, then add $5,$3,$4 behind it.
      tick();
      set_e(0, 0, 3, 1, 0);
      #1 check("idle_flush_d", Flush_D, 0);
      check("idle_flush_e", Flush_E, 0);
      tick();                                    // M: $3
      set_e(3, 4, 5, 1, 0);
      #1 check("b2b_fwd_a_mem", ForwardA_E, 2'b01);
      check("b2b_fwd_b_reg", ForwardB_E, 2'b00);
      tick();                                    // M: $5, W: $3
      set_e(3, 5, 0, 1, 0);                      // also writes $0
      #1 check("b2b_fwd_a_wb", ForwardA_E, 2'b10);
      check("b2b_fwd_b_mem", ForwardB_E, 2'b01);
      tick();                                    // M: $0, W: $5
      set_e(0, 0, 0, 1, 0);
      #1 check("zero_mem_fwd_a", ForwardA_E, 2'b00);
      check("zero_mem_fwd_b", ForwardB_E, 2'b00);
      tick();                                    // M: $0, W: $0
      set_e(0, 0, 6, 1, 0);
      #1 check("zero_wb_fwd_a", ForwardA_E, 2'b00);
      check("zero_wb_fwd_b", ForwardB_E, 2'b00);
      tick();                                    // M: $6
      set_e(0, 0, 6, 1, 0);
      tick();                                    // M: $6, W: $6
      set_e(6, 6, 9, 0, 0);
      #1 check("prio_fwd_a_mem", ForwardA_E, 2'b01);
      check("prio_fwd_b_mem", ForwardB_E, 2'b01);
      tick();                                    // M: $9 no write, W: $6
      set_e(6, 9, 0, 0, 0);
      #1 check("nowrite_fwd_a_wb", ForwardA_E, 2'b10);
      check("nowrite_fwd_b", ForwardB_E, 2'b00);

      // lw $2 in E, consumer with rt=$2 in D.
      tick();
      set_e(0, 0, 2, 1, 1);
      Rt_D = 2;
      #1 check("lw_stall_f", Stall_F, 1);
      check("lw_stall_d", Stall_D, 1);
      check("lw_flush_e", Flush_E, 1);
      check("lw_flush_d", Flush_D, 0);
      check("lw_stall_cnt_pre", stall_cnt, 0);
      tick();                                    // bubble enters E
      set_e(0, 0, 0, 0, 0);
      #1 check("lw_stall_cnt", stall_cnt, 1);
      check("lw_bubble_stall_d", Stall_D, 0);
      tick();                                    // consumer enters E, lw in WB
      Rt_D = 0;
      set_e(0, 2, 0, 0, 0);
      #1 check("lw_fwd_b_wb", ForwardB_E, 2'b10);

      // Taken branch together with a load-use condition.
      tick();
      set_e(0, 0, 4, 1, 1);
      Rs_D = 4; PCSrc_E = 1;
      #1 check("br_stall_f", Stall_F, 0);
      check("br_stall_d", Stall_D, 0);
      check("br_flush_d", Flush_D, 1);
      check("br_flush_e", Flush_E, 1);
      tick();
      PCSrc_E = 0;
      #1 check("br_flush_cnt", flush_cnt, 1);
      check("br_stall_cnt", stall_cnt, 1);

      // Jump in D together with a load-use condition: stall wins, D still flushed.
      Jump_D = 1;
      #1 check("jl_stall_d", Stall_D, 1);
      check("jl_flush_d", Flush_D, 1);
      check("jl_flush_e", Flush_E, 1);
      tick();
      Jump_D = 0; Rs_D = 0;
      set_e(0, 0, 0, 0, 0);
      #1 check("jl_stall_cnt", stall_cnt, 2);
      check("jl_flush_cnt", flush_cnt, 2);

      // Mid-stream reset with $7 in MEM.
      set_e(0, 0, 7, 1, 0);
      tick();                                    // M: $7
      set_e(7, 0, 7, 1, 1);
      Rs_D = 7;
      #1 check("pre_rst_fwd_a", ForwardA_E, 2'b01);
      check("pre_rst_stall_f", Stall_F, 1);
      RESET = 1'b1;
      #1 check("mid_rst_fwd_a", ForwardA_E, 2'b00);
      check("mid_rst_stall_f", Stall_F, 0);
      check("mid_rst_flush_d", Flush_D, 1);
      check("mid_rst_flush_e", Flush_E, 1);
      check("mid_rst_flush_cnt", flush_cnt, 0);
      check("mid_rst_stall_cnt", stall_cnt, 0);
      #1 RESET = 1'b0;
      set_e(7, 0, 0, 0, 0);
      Rs_D = 0;
      #1 check("post_rst_fwd_a", ForwardA_E, 2'b00);
      tick();
      #1 check("post_rst_fwd_a_clk", ForwardA_E, 2'b00);

      // Jump held for five cycles: 2-bit counter saturates at 3.
      Jump_D = 1;
      #1 check("jmp_flush_e", Flush_E, 0);
      check("jmp_stall_f", Stall_F, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("sat_flush_cnt_%0d", i), s_flush_cnt, (i > 3) ? 3 : i);
         check($sformatf("wide_flush_cnt_%0d", i), flush_cnt, i);
      end
      Jump_D = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
